// File: rtl/probe_buffer_mc.sv
// Purpose: multi-channel probe buffer. Per-channel FIFOs feed a round-robin arbiter that loads one registered output word.
// Latency: a word written at edge k is presented at edge k+1 at the earliest (FIFO and output empty, no competing channel).
// Backpressure: out_ready low holds the output word stable; FIFOs absorb it, and writes into a full FIFO are dropped and counted.
module probe_buffer_mc #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [CHANNELS-1:0]                    wen,
    input  logic [CHANNELS*WIDTH-1:0]              write,
    output logic [CHANNELS*WIDTH-1:0]              read,
    input  logic                                   flush,
    input  logic                                   clr_drop,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH-1:0]                       out_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic [CHANNELS-1:0]                    full
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [CW-1:0]    chan;
        logic [WIDTH-1:0] dat;
    } out_word_t;

    logic [CHANNELS-1:0] fifo_empty;
    logic [CHANNELS-1:0] fifo_full;
    logic [WIDTH-1:0]    fifo_dat [CHANNELS];
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] drop;

    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       rr_next;
    logic [CW-1:0]       gnt_idx;
    logic                gnt_vld;
    logic [CW:0]         scan_idx;
    logic                loadable;

    out_word_t           out_q;
    logic                out_vld_q;
    logic [CNT_W-1:0]    drop_cnt [CHANNELS];

    // The output register may take a new word when it is empty or its word leaves this cycle.
    assign loadable = !out_vld_q || out_ready;

    // Round-robin search over the pre-edge FIFO state, starting at rr_ptr and wrapping.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_idx = {1'b0, rr_ptr} + (CW+1)'(k);
            if (scan_idx >= (CW+1)'(CHANNELS)) begin
                scan_idx = scan_idx - (CW+1)'(CHANNELS);
            end
            if (!gnt_vld && !fifo_empty[scan_idx[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx[CW-1:0];
            end
        end
    end

    // Pointer after a grant: one past the winner, wrapping to channel 0.
    assign rr_next = (gnt_idx == CW'(CHANNELS-1)) ? '0 : gnt_idx + CW'(1);

    // Per-channel push/pop/drop; flush discards everything and nothing counts as a drop.
    // A full FIFO still accepts a word when the same FIFO is popped in this cycle.
    always_comb begin
        push = '0;
        pop  = '0;
        drop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop[i]  = !flush && loadable && gnt_vld && (gnt_idx == CW'(i));
            push[i] = !flush && wen[i] && (!fifo_full[i] || pop[i]);
            drop[i] = !flush && wen[i] && fifo_full[i] && !pop[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [AW:0]      cnt;

        assign fifo_empty[g] = (cnt == '0);
        assign fifo_full[g]  = (cnt == FULL_CNT);
        assign fifo_dat[g]   = mem[rd_ptr];
        assign full[g]       = fifo_full[g];
        assign read[g*WIDTH +: WIDTH] = WIDTH'(drop_cnt[g]);

        // Storage array; pointers alone define which entries are live, so no reset is needed.
        always_ff @(posedge clock) begin
            if (push[g]) begin
                mem[wr_ptr] <= write[g*WIDTH +: WIDTH];
            end
        end

        // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves cnt unchanged.
        always_ff @(posedge clock) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push[g], pop[g]})
                    2'b10:   cnt <= cnt + (AW+1)'(1);
                    2'b01:   cnt <= cnt - (AW+1)'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Output register and round-robin pointer; a stalled word holds until out_ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            rr_ptr    <= '0;
        end else if (loadable) begin
            if (gnt_vld) begin
                out_vld_q  <= 1'b1;
                out_q.chan <= gnt_idx;
                out_q.dat  <= fifo_dat[gnt_idx];
                rr_ptr     <= rr_next;
            end else begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    // Saturating drop counters; a clear that coincides with a drop leaves that drop counted.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!reset) begin
                drop_cnt[i] <= '0;
            end else if (clr_drop) begin
                drop_cnt[i] <= drop[i] ? CNT_W'(1) : '0;
            end else if (drop[i] && (drop_cnt[i] != CNT_MAX)) begin
                drop_cnt[i] <= drop_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_q.dat;
    assign out_chan  = out_q.chan;

endmodule
